mem_req_arbiter: RTL
====================

Name: mem_req_arbiter

Overview:
Two-requester round-robin arbiter and sequencer in front of the team's 32x8 single-address RAM (`we`/`re`/`addr`/`wdata` in, registered `rdata` out).
- Accepts one access per cycle from requester A or B.
- Drives the RAM command pins from registers.
- Routes the RAM's registered read data back to the requester that issued the read, with a valid strobe.
- Never issues a read and a write in the same cycle, so the RAM's shared address is never contended.

Parameters:
AW, 5, address width; memory depth is 2**AW (32)
DW, 8, data width

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
a_req  in  1  requester A access request; held with a_we/a_addr/a_wdata until a_gnt
a_we  in  1  A: 1=write, 0=read
a_addr  in  AW  A address
a_wdata  in  DW  A write data
a_gnt  out  1  A request accepted this cycle (combinational)
a_rvalid  out  1  A read data valid
a_rdata  out  DW  A read data
b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata  same as A, for requester B
mem_we  out  1  RAM write enable (registered)
mem_re  out  1  RAM read enable (registered)
mem_addr  out  AW  RAM address (registered)
mem_wdata  out  DW  RAM write data (registered)
mem_rdata  in  DW  RAM registered read data
busy  out  1  arbiter not accepting requests (init sweep)

Behaviour:
- FSM states: INIT (only with the optional feature), RUN.
- **Reset:** on rst, the FSM enters INIT if the feature is compiled in, otherwise RUN. Reset also forces:
  - all outputs to 0;
  - last_owner=B, so A wins the first contention;
  - read-tracking pipeline cleared.
- **Arbitration in RUN** (combinational within cycle t):
  - Only a_req: a_gnt=1.
  - Only b_req: b_gnt=1.
  - Both: grant the requester that is not last_owner.
  - At most one gnt is high per cycle.
  - last_owner updates at the clock edge ending cycle t.
- **Command issue:** at the edge ending cycle t, the winner's fields are registered onto the RAM pins:
  - mem_addr and mem_wdata take the winner's address and data;
  - mem_we = winner we;
  - mem_re = !winner we.
  - The command is visible during cycle t+1.
  - With no grant: mem_we=mem_re=0; mem_addr and mem_wdata hold their values.
- **Read return:**
  - The owner tag is pipelined for 2 stages alongside each read.
  - x_rvalid pulses for 1 cycle in cycle t+2, with x_rdata = mem_rdata (combinational pass-through).
  - x_rdata holds its last value when rvalid=0.
  - The non-owner's rvalid stays 0.
- **Throughput:** one access per cycle.
  - A requester holding req continuously gets back-to-back grants when alone.
  - With both holding req, grants alternate A,B,A,B.
- **Ordering:** a read granted in the cycle after a write to the same address returns the new data, because the RAM write lands at the edge before the read command executes.
- **Requester rule:** after gnt, the requester either deasserts req or presents the next access in the following cycle.
- **Reset mid-operation:** in-flight reads are discarded; no rvalid after reset.
- busy=0 in RUN; all gnt are 0 whenever busy=1.

Optional Feature:
Macro MEM_ARB_INIT_EN.
- **Defined:** after reset release the FSM is in INIT.
  - It issues DEPTH writes of data 0 to addresses 0..DEPTH-1, one per cycle, from an AW+1-bit counter.
  - busy=1 for exactly DEPTH cycles; requests are ignored and gnt is held 0.
  - After the last write it moves to RUN, busy=0, counter stops.
  - Reset during INIT restarts the sweep at address 0.
- **Not defined:** no INIT state or counter; FSM starts in RUN; busy tied to 0.

Test Plan:
- Reset, A writes 0x5A to addr 3, then A reads addr 3 -> mem_we=1, mem_addr=3, mem_wdata=0x5A one cycle after a_gnt; a_rvalid=1, a_rdata=0x5A two cycles after the read's a_gnt; b_rvalid=0.
- A and B both request continuously from reset (A reads addr 1, B reads addr 2) -> grants A,B,A,B; rvalid alternates a,b with data mem[1], mem[2].
- Same cycle, both request: A write addr 7=0x11, B read addr 7 -> A granted first; B granted next cycle; b_rdata=0x11.
- B alone holds b_req for 4 back-to-back reads, addrs 0..3 -> b_gnt high 4 consecutive cycles; 4 consecutive b_rvalid pulses in address order.
- Assert rst one cycle after a read grant -> no a_rvalid afterwards; all mem_* = 0 during reset.
- With MEM_ARB_INIT_EN: after reset release, busy=1 for 32 cycles; mem_we writes 0 to addrs 0..31; a_req during INIT gets no a_gnt; first grant in the cycle busy falls.

Source files
------------

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: two-requester round-robin arbiter and sequencer in front of
// a single-address RAM with registered read data.
//
// Handshake: a requester holds req together with its we/addr/wdata until it
// sees gnt high in the same cycle. The access is taken at the edge ending
// that cycle. Read data comes back two cycles after the grant as a one-cycle
// rvalid pulse to the requester that issued the read.
//
// Optional build macro MEM_ARB_INIT_EN: after reset, zero-fill the whole RAM
// (one write per cycle) before accepting requests. busy is high during the fill.
module mem_req_arbiter #(
    parameter int AW = 5,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_gnt,
    output logic          a_rvalid,
    output logic [DW-1:0] a_rdata,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_gnt,
    output logic          b_rvalid,
    output logic [DW-1:0] b_rdata,
    output logic          mem_we,
    output logic          mem_re,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

`ifdef MEM_ARB_INIT_EN
    localparam int DEPTH = 2 ** AW;
    typedef enum logic {ST_INIT, ST_RUN} state_t;
    localparam state_t RESET_STATE = ST_INIT;
    logic [AW:0] init_cnt;
`else
    typedef enum logic {ST_RUN} state_t;
    localparam state_t RESET_STATE = ST_RUN;
`endif

    state_t        state;
    logic          last_is_b;   // 1: B owned the last grant, so A wins the next tie
    logic          grant_en;
    logic          win_we;
    logic [AW-1:0] win_addr;
    logic [DW-1:0] win_wdata;

    // Read-tracking pipeline: stage 1 lines up with the RAM command cycle,
    // stage 2 with the cycle the RAM's registered data is valid.
    logic          rd1_v;
    logic          rd1_b;
    logic          rd2_v;
    logic          rd2_b;
    logic [DW-1:0] a_rdata_q;
    logic [DW-1:0] b_rdata_q;

    // Grants are only issued in RUN and never while reset is asserted.
    assign grant_en = (state == ST_RUN) && !rst;

`ifdef MEM_ARB_INIT_EN
    assign busy = (state == ST_INIT) && !rst;
`else
    assign busy = 1'b0;
`endif

    // Round-robin arbitration: on contention, the requester that did not win last time.
    always_comb begin
        a_gnt = grant_en && a_req && (!b_req || last_is_b);
        b_gnt = grant_en && b_req && (!a_req || !last_is_b);
    end

    // Select the winner's command fields.
    always_comb begin
        win_we    = a_we;
        win_addr  = a_addr;
        win_wdata = a_wdata;
        if (b_gnt) begin
            win_we    = b_we;
            win_addr  = b_addr;
            win_wdata = b_wdata;
        end
    end

    // Return read data to the issuing requester; rdata holds between pulses.
    always_comb begin
        a_rvalid = rd2_v && !rd2_b;
        b_rvalid = rd2_v && rd2_b;
        a_rdata  = a_rvalid ? mem_rdata : a_rdata_q;
        b_rdata  = b_rvalid ? mem_rdata : b_rdata_q;
    end

    // FSM, registered RAM command pins, ownership and read-tracking state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RESET_STATE;
            last_is_b <= 1'b1;
            mem_we    <= 1'b0;
            mem_re    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rd1_v     <= 1'b0;
            rd1_b     <= 1'b0;
            rd2_v     <= 1'b0;
            rd2_b     <= 1'b0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
`ifdef MEM_ARB_INIT_EN
            init_cnt  <= '0;
`endif
        end else begin
            rd2_v  <= rd1_v;
            rd2_b  <= rd1_b;
            rd1_v  <= 1'b0;
            mem_we <= 1'b0;
            mem_re <= 1'b0;
            if (a_rvalid) a_rdata_q <= mem_rdata;
            if (b_rvalid) b_rdata_q <= mem_rdata;

            // gnt is only ever high in RUN, so this is the RUN-state command issue.
            if (a_gnt || b_gnt) begin
                mem_we    <= win_we;
                mem_re    <= !win_we;
                mem_addr  <= win_addr;
                mem_wdata <= win_wdata;
                last_is_b <= b_gnt;
                rd1_v     <= !win_we;
                rd1_b     <= b_gnt;
            end

`ifdef MEM_ARB_INIT_EN
            // Zero-fill sweep, one address per cycle, then hand over to RUN.
            if (state == ST_INIT) begin
                mem_we    <= 1'b1;
                mem_addr  <= init_cnt[AW-1:0];
                mem_wdata <= '0;
                init_cnt  <= init_cnt + 1'b1;
                if (init_cnt == (AW+1)'(DEPTH - 1)) begin
                    state <= ST_RUN;
                end
            end
`endif
        end
    end

endmodule
